// File: rtl/dll_ctrl.sv
// DLL bring-up controller: drives DLL reset, waits for stable lock with timeout/retry,
// and accepts validated delay-setting updates through a valid/ready handshake.
module dll_ctrl #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 200,
  parameter int unsigned LOCK_STABLE  = 4,
  parameter int unsigned MAX_RETRY    = 2,
  parameter logic [7:0]  ADJ_INIT     = 8'd0,
  parameter logic [7:0]  MADJ_INIT    = 8'd64
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       io_start,
  input  logic       io_cfg_valid,
  output logic       io_cfg_ready,
  input  logic [7:0] io_cfg_adj,
  input  logic [7:0] io_cfg_madj,
  input  logic       io_dll_lock,
  output logic       io_dll_reset,
  output logic [7:0] io_adj,
  output logic [7:0] io_madj,
  output logic       io_ready,
  output logic       io_error,
  output logic       io_cfg_err,
  output logic [3:0] io_retry_cnt
);

  typedef enum logic [2:0] {StIdle, StReset, StWaitLock, StLocked, StError} state_e;

  state_e      state_q, state_d;
  logic [7:0]  rst_cnt_q, rst_cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic [3:0]  stable_q, stable_d, stable_inc;
  logic [3:0]  retry_q, retry_d;
  logic [7:0]  adj_q, adj_d, madj_q, madj_d;
  logic        cfg_err_q, cfg_err_d;
  logic        cfg_take, cfg_legal, cfg_update;

  always_comb begin
    io_cfg_ready = (state_q == StIdle) || (state_q == StLocked) || (state_q == StError);
    io_dll_reset = (state_q == StIdle) || (state_q == StReset) || (state_q == StError);
    io_ready     = (state_q == StLocked);
    io_error     = (state_q == StError);
    io_adj       = adj_q;
    io_madj      = madj_q;
    io_cfg_err   = cfg_err_q;
    io_retry_cnt = retry_q;
  end

  always_comb begin
    cfg_take   = io_cfg_valid && io_cfg_ready;
    cfg_legal  = (io_cfg_madj != 8'd0) && (io_cfg_adj <= io_cfg_madj);
    cfg_update = cfg_take && cfg_legal;
    stable_inc = stable_q + 4'd1;
  end

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    to_cnt_d  = to_cnt_q;
    stable_d  = stable_q;
    retry_d   = retry_q;
    adj_d     = adj_q;
    madj_d    = madj_q;
    cfg_err_d = cfg_take && !cfg_legal;

    if (cfg_update) begin
      adj_d  = io_cfg_adj;
      madj_d = io_cfg_madj;
    end

    unique case (state_q)
      StIdle, StError: begin
        if (io_start) begin
          state_d   = StReset;
          rst_cnt_d = 8'(RST_CYCLES);
          retry_d   = 4'd0;
        end
      end
      StReset: begin
        rst_cnt_d = rst_cnt_q - 8'd1;
        if (rst_cnt_q == 8'd1) begin
          state_d  = StWaitLock;
          to_cnt_d = 16'(LOCK_TIMEOUT);
          stable_d = 4'd0;
        end
      end
      StWaitLock: begin
        to_cnt_d = to_cnt_q - 16'd1;
        stable_d = io_dll_lock ? stable_inc : 4'd0;
        // Lock wins over a timeout expiring in the same cycle.
        if (io_dll_lock && (stable_inc == 4'(LOCK_STABLE))) begin
          state_d = StLocked;
        end else if (to_cnt_q == 16'd1) begin
          if (retry_q < 4'(MAX_RETRY)) begin
            retry_d   = retry_q + 4'd1;
            state_d   = StReset;
            rst_cnt_d = 8'(RST_CYCLES);
          end else begin
            state_d = StError;
          end
        end
      end
      StLocked: begin
        if (!io_dll_lock || cfg_update) begin
          state_d  = StWaitLock;
          to_cnt_d = 16'(LOCK_TIMEOUT);
          stable_d = 4'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      rst_cnt_q <= 8'd0;
      to_cnt_q  <= 16'd0;
      stable_q  <= 4'd0;
      retry_q   <= 4'd0;
      adj_q     <= ADJ_INIT;
      madj_q    <= MADJ_INIT;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      to_cnt_q  <= to_cnt_d;
      stable_q  <= stable_d;
      retry_q   <= retry_d;
      adj_q     <= adj_d;
      madj_q    <= madj_d;
      cfg_err_q <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_dll_ctrl.sv
// Self-checking bench for dll_ctrl: phase/elapsed-time model compared every cycle,
// plus directed scenarios with hand-computed cycle counts and values.
module tb_dll_ctrl;

  localparam int RST     = 16;
  localparam int TIMEOUT = 200;
  localparam int STABLE  = 4;
  localparam int RETRY   = 2;

  logic       clock;
  logic       reset_n;
  logic       io_start;
  logic       io_cfg_valid;
  logic       io_cfg_ready;
  logic [7:0] io_cfg_adj;
  logic [7:0] io_cfg_madj;
  logic       io_dll_lock;
  logic       io_dll_reset;
  logic [7:0] io_adj;
  logic [7:0] io_madj;
  logic       io_ready;
  logic       io_error;
  logic       io_cfg_err;
  logic [3:0] io_retry_cnt;

  dll_ctrl #(
    .RST_CYCLES  (RST),
    .LOCK_TIMEOUT(TIMEOUT),
    .LOCK_STABLE (STABLE),
    .MAX_RETRY   (RETRY),
    .ADJ_INIT    (8'd0),
    .MADJ_INIT   (8'd64)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .io_start    (io_start),
    .io_cfg_valid(io_cfg_valid),
    .io_cfg_ready(io_cfg_ready),
    .io_cfg_adj  (io_cfg_adj),
    .io_cfg_madj (io_cfg_madj),
    .io_dll_lock (io_dll_lock),
    .io_dll_reset(io_dll_reset),
    .io_adj      (io_adj),
    .io_madj     (io_madj),
    .io_ready    (io_ready),
    .io_error    (io_error),
    .io_cfg_err  (io_cfg_err),
    .io_retry_cnt(io_retry_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk;
  int n_pass;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s @%0t: got %0d, required %0d", name, $time, act, req);
  endtask

  // Model: which phase we are in and how many cycles have elapsed in it.
  typedef enum logic [2:0] {MIdle, MReset, MWait, MLocked, MError} mode_t;
  typedef struct packed {
    mode_t      mode;
    int         elapsed;
    int         run;
    int         retry;
    logic [7:0] adj;
    logic [7:0] madj;
    logic       cfg_err;
  } model_t;

  model_t m;

  function automatic model_t model_step(input model_t s, input logic start, input logic lock,
                                        input logic cv, input logic [7:0] ca,
                                        input logic [7:0] cm);
    model_t n;
    logic   rdy;
    logic   legal;
    logic   take;
    n     = s;
    rdy   = (s.mode == MIdle) || (s.mode == MLocked) || (s.mode == MError);
    legal = (cm != 8'd0) && (ca <= cm);
    take  = cv && rdy && legal;
    n.cfg_err = cv && rdy && !legal;
    if (take) begin
      n.adj  = ca;
      n.madj = cm;
    end
    case (s.mode)
      MIdle, MError: if (start) begin
        n.mode = MReset; n.elapsed = 0; n.retry = 0;
      end
      MReset: begin
        n.elapsed = s.elapsed + 1;
        if (n.elapsed == RST) begin
          n.mode = MWait; n.elapsed = 0; n.run = 0;
        end
      end
      MWait: begin
        n.elapsed = s.elapsed + 1;
        n.run     = lock ? s.run + 1 : 0;
        if (n.run == STABLE) n.mode = MLocked;
        else if (n.elapsed == TIMEOUT) begin
          if (s.retry < RETRY) begin
            n.retry = s.retry + 1; n.mode = MReset; n.elapsed = 0;
          end else begin
            n.mode = MError;
          end
        end
      end
      MLocked: if (!lock || take) begin
        n.mode = MWait; n.elapsed = 0; n.run = 0;
      end
      default: ;
    endcase
    return n;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m.mode    <= MIdle;
      m.elapsed <= 0;
      m.run     <= 0;
      m.retry   <= 0;
      m.adj     <= 8'd0;
      m.madj    <= 8'd64;
      m.cfg_err <= 1'b0;
    end else begin
      m <= model_step(m, io_start, io_dll_lock, io_cfg_valid, io_cfg_adj, io_cfg_madj);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      check("m_cfg_ready", 32'(io_cfg_ready),
            32'((m.mode == MIdle) || (m.mode == MLocked) || (m.mode == MError)));
      check("m_dll_reset", 32'(io_dll_reset),
            32'((m.mode == MIdle) || (m.mode == MReset) || (m.mode == MError)));
      check("m_ready", 32'(io_ready), 32'(m.mode == MLocked));
      check("m_error", 32'(io_error), 32'(m.mode == MError));
      check("m_cfg_err", 32'(io_cfg_err), 32'(m.cfg_err));
      check("m_adj", 32'(io_adj), 32'(m.adj));
      check("m_madj", 32'(io_madj), 32'(m.madj));
      check("m_retry", 32'(io_retry_cnt), 32'(m.retry));
    end
  end

  int n;
  int lows;
  logic [0:7] pat_lock;
  logic [0:7] pat_rdy;

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset_n = 1'b0;
    io_start = 1'b0;
    io_cfg_valid = 1'b0;
    io_cfg_adj = 8'd0;
    io_cfg_madj = 8'd0;
    io_dll_lock = 1'b0;
    #23 reset_n = 1'b1;
    @(negedge clock);

    check("rst_dll_reset", 32'(io_dll_reset), 32'd1);
    check("rst_cfg_ready", 32'(io_cfg_ready), 32'd1);
    check("rst_adj", 32'(io_adj), 32'd0);
    check("rst_madj", 32'(io_madj), 32'd64);
    check("rst_ready", 32'(io_ready), 32'd0);
    check("rst_retry", 32'(io_retry_cnt), 32'd0);

    // Normal bring-up: lock 100 cycles after DLL reset falls
    io_start = 1'b1;
    @(negedge clock);
    io_start = 1'b0;
    n = 0;
    while (io_dll_reset && n < 1000) begin n++; @(negedge clock); end
    check("reset_len", 32'(n), 32'd16);
    repeat (100) @(negedge clock);
    io_dll_lock = 1'b1;
    n = 0;
    while (!io_ready && n < 1000) begin @(negedge clock); n++; end
    check("lock_to_ready", 32'(n), 32'd4);
    check("retry_after_lock", 32'(io_retry_cnt), 32'd0);

    // Legal config in LOCKED forces relock
    io_cfg_valid = 1'b1; io_cfg_adj = 8'd32; io_cfg_madj = 8'd64;
    @(negedge clock);
    io_cfg_valid = 1'b0;
    check("cfg_adj", 32'(io_adj), 32'd32);
    check("cfg_madj", 32'(io_madj), 32'd64);
    check("cfg_ready_drop", 32'(io_ready), 32'd0);
    n = 0;
    while (!io_ready && n < 1000) begin @(negedge clock); n++; end
    check("cfg_relock", 32'(n), 32'd4);

    // Illegal configs: madj=0, then adj>madj
    for (int i = 0; i < 2; i++) begin
      io_cfg_valid = 1'b1;
      io_cfg_adj   = (i == 0) ? 8'd0 : 8'd65;
      io_cfg_madj  = (i == 0) ? 8'd0 : 8'd64;
      @(negedge clock);
      io_cfg_valid = 1'b0;
      check("bad_cfg_err", 32'(io_cfg_err), 32'd1);
      check("bad_cfg_adj", 32'(io_adj), 32'd32);
      check("bad_cfg_madj", 32'(io_madj), 32'd64);
      check("bad_cfg_ready", 32'(io_ready), 32'd1);
      @(negedge clock);
      check("bad_cfg_pulse", 32'(io_cfg_err), 32'd0);
    end

    // Boundary: adj == madj is legal
    io_cfg_valid = 1'b1; io_cfg_adj = 8'd64; io_cfg_madj = 8'd64;
    @(negedge clock);
    io_cfg_valid = 1'b0;
    check("eq_cfg_err", 32'(io_cfg_err), 32'd0);
    check("eq_cfg_adj", 32'(io_adj), 32'd64);
    check("eq_cfg_ready", 32'(io_ready), 32'd0);
    n = 0;
    while (!io_ready && n < 1000) begin @(negedge clock); n++; end
    check("eq_relock", 32'(n), 32'd4);

    // Lock drop, then broken lock run 3-high/1-low/4-high
    io_dll_lock = 1'b0;
    @(negedge clock);
    check("drop_ready", 32'(io_ready), 32'd0);
    pat_lock = 8'b1110_1111;
    pat_rdy  = 8'b0000_0001;
    for (int i = 0; i < 8; i++) begin
      io_dll_lock = pat_lock[i];
      @(negedge clock);
      check("pattern_ready", 32'(io_ready), 32'(pat_rdy[i]));
    end
    io_dll_lock = 1'b0;
    @(negedge clock);
    check("blip_ready", 32'(io_ready), 32'd0);
    io_dll_lock = 1'b1;
    @(negedge clock);

    // Asynchronous reset mid-WAIT_LOCK, checked before any clock edge
    #2 reset_n = 1'b0;
    #1;
    check("areset_dll_reset", 32'(io_dll_reset), 32'd1);
    check("areset_adj", 32'(io_adj), 32'd0);
    check("areset_madj", 32'(io_madj), 32'd64);
    check("areset_ready", 32'(io_ready), 32'd0);
    check("areset_error", 32'(io_error), 32'd0);
    check("areset_cfg_err", 32'(io_cfg_err), 32'd0);
    check("areset_retry", 32'(io_retry_cnt), 32'd0);
    check("areset_cfg_ready", 32'(io_cfg_ready), 32'd1);
    io_dll_lock = 1'b0;
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);

    // Config + start together, then lock never arrives -> ERROR
    io_start = 1'b1; io_cfg_valid = 1'b1; io_cfg_adj = 8'd10; io_cfg_madj = 8'd20;
    @(negedge clock);
    io_start = 1'b0; io_cfg_valid = 1'b0;
    check("both_adj", 32'(io_adj), 32'd10);
    check("both_madj", 32'(io_madj), 32'd20);
    check("both_cfg_ready", 32'(io_cfg_ready), 32'd0);
    check("both_dll_reset", 32'(io_dll_reset), 32'd1);
    n = 0;
    lows = 0;
    while (!io_error && n < 2000) begin
      if (!io_dll_reset) lows++;
      io_start = (n == 100);  // lands in WAIT_LOCK and must be ignored
      @(negedge clock);
      n++;
    end
    io_start = 1'b0;
    check("error_time", 32'(n), 32'd648);
    check("wait_cycles", 32'(lows), 32'd600);
    check("err_retry", 32'(io_retry_cnt), 32'd2);
    check("err_cfg_ready", 32'(io_cfg_ready), 32'd1);
    check("err_dll_reset", 32'(io_dll_reset), 32'd1);

    // Restart from ERROR clears retry count
    io_start = 1'b1;
    @(negedge clock);
    io_start = 1'b0;
    check("restart_retry", 32'(io_retry_cnt), 32'd0);
    check("restart_error", 32'(io_error), 32'd0);
    check("restart_dll_reset", 32'(io_dll_reset), 32'd1);
    repeat (20) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dll_ctrl.md
DLL_CTRL -- requirements
Module: dll_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16, meaning cycles io_dll_reset is held high per bring-up attempt (1..255).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 200, meaning max cycles in WAIT_LOCK per attempt (1..65535).
REQ-003 SHALL have parameter LOCK_STABLE, default 4, meaning consecutive io_dll_lock-high cycles required to declare lock (1..15).
REQ-004 SHALL have parameter MAX_RETRY, default 2, meaning re-attempts after the first timeout before ERROR (0..15).
REQ-005 SHALL have parameters ADJ_INIT (default 0) and MADJ_INIT (default 64), meaning reset values of io_adj and io_madj.
REQ-006 clock  in  1  controller clock, same as DLL reference clock; all logic on rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 io_start  in  1  level; begins bring-up when sampled high in IDLE or ERROR.
REQ-009 io_cfg_valid / io_cfg_ready  in / out  1 / 1  valid-ready handshake for a new delay setting.
REQ-010 io_cfg_adj / io_cfg_madj  in  8 / 8  requested numerator / denominator of the DLL delay.
REQ-011 io_dll_lock  in  1  DLL lock indication.
REQ-012 io_dll_reset  out  1  DLL reset.
REQ-013 io_adj / io_madj  out  8 / 8  programmed delay numerator / denominator to the DLL.
REQ-014 io_ready  out  1  DLL locked and usable.
REQ-015 io_error  out  1  bring-up failed after all retries.
REQ-016 io_cfg_err  out  1  one-cycle pulse: an accepted config was illegal and discarded.
REQ-017 io_retry_cnt  out  4  retries consumed in current bring-up.

Function
REQ-018 SHALL implement states IDLE, RESET, WAIT_LOCK, LOCKED, ERROR; all outputs registered/decoded from state, no input-to-output combinational paths.
REQ-019 io_dll_reset SHALL be 1 in IDLE, RESET, ERROR and 0 in WAIT_LOCK, LOCKED; io_ready SHALL be 1 only in LOCKED; io_error SHALL be 1 only in ERROR.
REQ-020 IDLE/ERROR + io_start=1 -> RESET next cycle, reset counter loaded with RST_CYCLES, io_retry_cnt cleared to 0; io_start ignored in all other states.
REQ-021 RESET SHALL last exactly RST_CYCLES cycles, then -> WAIT_LOCK with timeout counter loaded with LOCK_TIMEOUT and stable counter cleared.
REQ-022 WAIT_LOCK: stable counter increments each cycle io_dll_lock=1, clears to 0 on any cycle io_dll_lock=0; reaching LOCK_STABLE -> LOCKED next cycle.
REQ-023 WAIT_LOCK: timeout counter decrements each cycle; on expiry without lock, if io_retry_cnt < MAX_RETRY -> increment io_retry_cnt, -> RESET; else -> ERROR.
REQ-024 Lock and timeout reaching terminal value in the same cycle SHALL resolve to LOCKED.
REQ-025 LOCKED + io_dll_lock=0 -> WAIT_LOCK next cycle with fresh timeout, stable counter cleared, io_retry_cnt unchanged.
REQ-026 io_cfg_ready SHALL be 1 in IDLE, LOCKED, ERROR and 0 in RESET, WAIT_LOCK.
REQ-027 Config accepted when io_cfg_valid & io_cfg_ready; legal iff io_cfg_madj != 0 and io_cfg_adj <= io_cfg_madj (unsigned 8-bit compare).
REQ-028 Legal accepted config SHALL update io_adj/io_madj the next cycle; if in LOCKED, state -> WAIT_LOCK the same next cycle (fresh timeout, stable cleared).
REQ-029 Illegal accepted config SHALL leave io_adj, io_madj, state unchanged and pulse io_cfg_err high for exactly one cycle.
REQ-030 Config and io_start accepted in the same cycle (IDLE/ERROR) SHALL both take effect: new io_adj/io_madj and -> RESET.
REQ-031 Counters SHALL saturate/reload only as stated; no wrap-around of io_retry_cnt beyond MAX_RETRY.

Reset
REQ-032 reset_n=0 SHALL immediately force state IDLE, io_dll_reset=1, io_adj=ADJ_INIT, io_madj=MADJ_INIT, io_ready=0, io_error=0, io_cfg_err=0, io_retry_cnt=0, io_cfg_ready=1, all counters 0, regardless of clock, including mid-operation.

Verification (defaults)
REQ-033 io_start pulse at cycle 0, DLL model locks 100 cycles after io_dll_reset falls -> io_dll_reset high 16 cycles after start accepted, io_ready rises 4 cycles after lock rises, io_retry_cnt=0.
REQ-034 io_dll_lock tied 0 -> three WAIT_LOCK windows of 200 cycles each separated by 16-cycle resets, then io_error=1, io_retry_cnt=2, io_cfg_ready=1; io_start then clears io_retry_cnt and restarts.
REQ-035 In LOCKED, cfg adj=32 madj=64 -> io_adj=32/io_madj=64 and io_ready=0 next cycle; io_ready returns after lock stable 4 cycles.
REQ-036 In LOCKED, cfg madj=0 or adj=65 madj=64 -> io_cfg_err one-cycle pulse, io_adj/io_madj/io_ready unchanged.
REQ-037 In WAIT_LOCK, lock high 3 cycles, low 1, high 4 -> LOCKED only after the final 4; in LOCKED, 1-cycle lock drop -> io_ready=0 next cycle.
REQ-038 reset_n asserted mid-WAIT_LOCK between clock edges -> all outputs at REQ-032 values before the next edge.
